// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment driver. One clk_div bit paces the digit
// scan, another supplies the blink phase; anode and segment drives are active-low.
module seg_scan #(
   parameter int SCAN_BIT  = 17,
   parameter int BLINK_BIT = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] clk_div,
   input  logic [15:0] hexs,
   input  logic [3:0]  points,
   input  logic [3:0]  LEs,
   input  logic [3:0]  blink,
   output logic [3:0]  AN,
   output logic [7:0]  SEGMENT
);

   logic [1:0] idx_q,   idx_d;
   logic       scan_q,  scan_d;
   logic       blink_q, blink_d;
   logic [3:0] an_q,    an_d;
   logic [7:0] seg_q,   seg_d;

   logic       tick;
   logic       blank;
   logic [3:0] nibble;
   logic       unused_div;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
   function automatic logic [6:0] seg7(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      unused_div = ^clk_div;
      scan_d     = clk_div[SCAN_BIT];
      blink_d    = clk_div[BLINK_BIT];
      // Rising edge of the scan bit relative to its value one cycle earlier.
      tick       = clk_div[SCAN_BIT] & ~scan_q;
      idx_d      = tick ? idx_q + 2'd1 : idx_q;
      nibble     = hexs[{idx_q, 2'b00} +: 4];
      blank      = ~LEs[idx_q] | (blink[idx_q] & blink_q);
      an_d       = 4'hF;
      seg_d      = 8'hFF;
      if (!blank) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = {~points[idx_q], seg7(nibble)};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= 2'd0;
         scan_q  <= 1'b0;
         blink_q <= 1'b0;
         an_q    <= 4'hF;
         seg_q   <= 8'hFF;
      end else begin
         idx_q   <= idx_d;
         scan_q  <= scan_d;
         blink_q <= blink_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign AN      = an_q;
   assign SEGMENT = seg_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with a fast scan bit (0) and blink bit (1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg_scan;

   logic        clk;
   logic        rst;
   logic [31:0] clk_div;
   logic [15:0] hexs;
   logic [3:0]  points;
   logic [3:0]  LEs;
   logic [3:0]  blink;
   logic [3:0]  AN;
   logic [7:0]  SEGMENT;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected segment byte with dp off, digits 0..F.
   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   seg_scan #(.SCAN_BIT(0), .BLINK_BIT(1)) dut (
      .clk     (clk),
      .rst     (rst),
      .clk_div (clk_div),
      .hexs    (hexs),
      .points  (points),
      .LEs     (LEs),
      .blink   (blink),
      .AN      (AN),
      .SEGMENT (SEGMENT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] an_e, input logic [7:0] seg_e);
      check({tag, " AN"}, {4'h0, AN}, {4'h0, an_e});
      check({tag, " SEG"}, SEGMENT, seg_e);
   endtask

   // Rising edge on the scan bit, then back low; the new digit shows at the second sample.
   task automatic scan_tick(input logic [3:0] an_prev);
      clk_div[0] = 1'b1;
      @(negedge clk);
      check("tick latency AN", {4'h0, AN}, {4'h0, an_prev});
      clk_div[0] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst     = 1'b1;
      clk_div = 32'h0;
      hexs    = 16'h3210;
      points  = 4'h0;
      LEs     = 4'hF;
      blink   = 4'h0;
      repeat (3) @(negedge clk);
      chk_out("reset", 4'hF, 8'hFF);

      rst = 1'b0;
      @(negedge clk);
      chk_out("post reset", 4'b1110, 8'hC0);

      // Scan order through all four digits and back to digit 0.
      for (int k = 1; k <= 4; k++) begin
         scan_tick(an_tab[(k - 1) % 4]);
         chk_out($sformatf("scan %0d", k % 4), an_tab[k % 4], seg_tab[k % 4]);
      end

      // A held-high scan bit produces only a single advance.
      clk_div[0] = 1'b1;
      repeat (2) @(negedge clk);
      check("held first AN", {4'h0, AN}, {4'h0, 4'b1101});
      repeat (6) @(negedge clk);
      chk_out("held steady", 4'b1101, 8'hF9);
      clk_div[0] = 1'b0;
      @(negedge clk);

      // Reset asserted mid-scan on digit 2 clears the outputs immediately.
      scan_tick(4'b1101);
      chk_out("pre reset idx2", 4'b1011, 8'hA4);
      #2 rst = 1'b1;
      #1 chk_out("async reset", 4'hF, 8'hFF);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_out("release idx0", 4'b1110, 8'hC0);

      // Decode sweep on digit 0.
      for (int h = 0; h < 16; h++) begin
         hexs[3:0] = 4'(h);
         @(negedge clk);
         chk_out($sformatf("decode %h", h), 4'b1110, seg_tab[h]);
      end
      hexs[3:0] = 4'h0;
      points[0] = 1'b1;
      @(negedge clk);
      chk_out("dp digit0", 4'b1110, 8'h40);
      points[0] = 1'b0;
      @(negedge clk);

      // Digit 2 disabled: its slot is dark, the rest unaffected.
      LEs = 4'b1011;
      for (int k = 1; k <= 4; k++) begin
         scan_tick((k - 1) % 4 == 2 ? 4'hF : an_tab[(k - 1) % 4]);
         if (k % 4 == 2) chk_out("blank slot2", 4'hF, 8'hFF);
         else chk_out($sformatf("enabled slot %0d", k % 4), an_tab[k % 4], seg_tab[k % 4]);
      end
      LEs = 4'hF;
      @(negedge clk);

      // Blink on digit 0 follows the registered blink phase.
      blink      = 4'b0001;
      clk_div[1] = 1'b1;
      @(negedge clk);
      chk_out("blink phase lag", 4'b1110, 8'hC0);
      @(negedge clk);
      chk_out("blink dark", 4'hF, 8'hFF);
      clk_div[1] = 1'b0;
      @(negedge clk);
      chk_out("blink dark lag", 4'hF, 8'hFF);
      @(negedge clk);
      chk_out("blink lit", 4'b1110, 8'hC0);
      clk_div[1] = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         scan_tick((k - 1) % 4 == 0 && k != 1 ? 4'hF : an_tab[(k - 1) % 4]);
         if (k % 4 == 0) chk_out("blink dark wrap", 4'hF, 8'hFF);
         else chk_out($sformatf("no blink %0d", k % 4), an_tab[k % 4], seg_tab[k % 4]);
      end
      clk_div[1] = 1'b0;
      blink      = 4'h0;
      @(negedge clk);

      // Scan bit already high at reset release: tick in the first cycle.
      rst        = 1'b1;
      clk_div[0] = 1'b1;
      @(negedge clk);
      chk_out("reset again", 4'hF, 8'hFF);
      rst = 1'b0;
      @(negedge clk);
      check("first tick lag AN", {4'h0, AN}, {4'h0, 4'b1110});
      @(negedge clk);
      chk_out("first tick idx1", 4'b1101, 8'hF9);
      for (int k = 1; k <= 4; k++) begin
         clk_div[0] = 1'b0;
         @(negedge clk);
         clk_div[0] = 1'b1;
         repeat (2) @(negedge clk);
         check($sformatf("wrap step %0d AN", k), {4'h0, AN}, {4'h0, an_tab[(1 + k) % 4]});
      end
      chk_out("wrap back idx1", 4'b1101, 8'hF9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
